ime_ctrl_seq: RTL and testbench
===============================

Name: ime_ctrl_seq

Overview:
- Parametrised IME command sequencer.
- Runs up to 2^CMD_NUM_WIDTH search commands per CTU. For each command it loads the search window and mode configuration, then sequences the address, decision and dump sub-engines.
- Adds three capabilities: per-command enable (skip), synchronous abort, and a busy/index status. An optional stall watchdog can be compiled in.
- Sits between the encoder top-level controller and the IME datapath engines (adr/dec/dmp).

Parameters:
- CMD_NUM_WIDTH, 3: command index width; the command slot count is 2^CMD_NUM_WIDTH.
- MV_X_WIDTH, 7: width of center_x. length_x is MV_X_WIDTH-1 bits.
- MV_Y_WIDTH, 6: width of center_y. length_y is MV_Y_WIDTH-1 bits.
- WDT_WIDTH, 12: watchdog counter width. Only used with IME_CTRL_SEQ_WDT_EN.
- Derived: CMD_W = 2*MV_X_WIDTH + 2*MV_Y_WIDTH + 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_num_i  in  CMD_NUM_WIDTH  index of the last command. Latched at start.
- cmd_dat_i  in  CMD_W*2^CMD_NUM_WIDTH  packed commands. Must be stable from start until done.
- start_i  in  1  start pulse. Honoured in IDLE only.
- abort_i  in  1  cancel the current run.
- done_o  out  1  one-cycle run-complete pulse.
- abort_o  out  1  one-cycle pulse, coincident with done_o, when a run ended by abort or timeout.
- timeout_o  out  1  one-cycle pulse, coincident with done_o, when the watchdog fired.
- busy_o  out  1  high whenever the state is not IDLE.
- cmd_idx_o  out  CMD_NUM_WIDTH  current command index.
- center_x_o  out  MV_X_WIDTH  search center x.
- center_y_o  out  MV_Y_WIDTH  search center y.
- length_x_o  out  MV_X_WIDTH-1  search length x.
- length_y_o  out  MV_Y_WIDTH-1  search length y.
- slope_o  out  2  window slope.
- downsample_o  out  1  downsample mode.
- use_feedback_o  out  1  use feedback MV.
- start_adr_o, start_dec_o, start_dmp_o  out  1 each  sub-engine start pulses.
- done_adr_i, done_dec_i, done_dmp_i  in  1 each  sub-engine done pulses.

Behaviour:
- Command packing: command k occupies bits [CMD_W*(k+1)-1 : CMD_W*k].
  - Fields, MSB to LSB: en, center_x, center_y, length_x, length_y, slope, downsample, partition, use_feedback.
- States:
  - IDLE: on start_i go to UPDATE; latch cmd_num_i; clear cmd_idx.
  - UPDATE: load command cmd_idx into the cfg outputs and the internal partition flag.
    - If en=0 and cmd_idx != latched num: increment cmd_idx and stay in UPDATE. The cfg outputs still load; the skip costs 1 cycle per command.
    - Otherwise go to BUSY_ADR. The last command always executes regardless of en.
  - BUSY_ADR: wait for done_adr_i, then go to BUSY_DEC.
  - BUSY_DEC: decision phase.
    - Completes on done_dec_i; or immediately when partition=0 and the command is not the last.
    - On completion: if last, go to BUSY_DMP; else increment cmd_idx and go to UPDATE.
  - BUSY_DMP: wait for done_dmp_i, then go to IDLE.
- Start/done pulses are registered on a state transition and are high exactly in the first cycle of the new state.
  - start_dec_o is asserted only if partition=1 or the command is the last.
  - done_o is high in the first IDLE cycle after a run.
- Latency: start_i in cycle 0 gives UPDATE in cycle 1, and start_adr_o plus valid cfg in cycle 2.
- Abort: abort_i=1 in any non-IDLE state sends the FSM to IDLE next cycle.
  - done_o=abort_o=1 for one cycle; cmd_idx clears.
  - Sub-engine done inputs in the same cycle are ignored; no start pulse is issued.
  - abort_i in IDLE has no effect.
  - start_i and abort_i together in IDLE: the start is accepted.
- start_i while busy is ignored.
- cmd_num_i changes after start have no effect.
- A done_*_i arriving in a state that does not wait on it is ignored.
- Reset values: all outputs 0, state IDLE, cmd_idx 0, partition 0.
  - Reset mid-run returns to IDLE immediately and issues no done_o.

Optional Feature:
- Macro: IME_CTRL_SEQ_WDT_EN.
- Defined:
  - A WDT_WIDTH counter clears on every state change and increments in BUSY_ADR, BUSY_DEC and BUSY_DMP.
  - When it reaches 2^WDT_WIDTH-1, the FSM takes the abort path with timeout_o=1 as well.
- Undefined: no counter is built; timeout_o is tied to 0.

Test Plan:
- Single command: cmd_num=0, cmd0 {en=1,cx=5,cy=-3,partition=0}.
  - start → start_adr_o at cycle 2 with center_x_o=5, center_y_o=6'h3D.
  - done_adr → start_dec_o=1 (last command forced); done_dec → start_dmp_o; done_dmp → done_o=1, abort_o=0.
- Two commands, cmd0 partition=0, cmd1 partition=1, both en=1.
  - After done_adr for cmd0 there is no start_dec_o; UPDATE follows immediately with cmd_idx_o=1.
  - Then 2 start_adr_o pulses total and 1 start_dec_o total.
- Skip: cmd_num=3, en=0 for cmds 1 and 2.
  - Exactly 2 start_adr_o pulses, with cmd_idx_o 0 then 3.
  - cmd3 runs even with en=0.
- Abort in BUSY_DEC with done_dec_i in the same cycle → next cycle IDLE, done_o=abort_o=1, no start_dmp_o. A new start_i is then accepted.
- Watchdog (macro on, WDT_WIDTH=4): hold done_adr_i low → after 15 BUSY_ADR cycles done_o=abort_o=timeout_o=1.
  - With the macro off, busy_o stays 1 indefinitely.
- Reset asserted in BUSY_DMP → all outputs 0 at once, busy_o=0, no done_o after release.

Source files
------------

// File: rtl/ime_ctrl_seq.sv
// IME command sequencer: walks the packed command table and drives the adr/dec/dmp engines.
// Optional stall watchdog is compiled in with IME_CTRL_SEQ_WDT_EN.
module ime_ctrl_seq #(
  parameter int unsigned CMD_NUM_WIDTH = 3,
  parameter int unsigned MV_X_WIDTH    = 7,
  parameter int unsigned MV_Y_WIDTH    = 6,
  parameter int unsigned WDT_WIDTH     = 12,
  localparam int unsigned CMD_W        = 2 * MV_X_WIDTH + 2 * MV_Y_WIDTH + 4,
  localparam int unsigned NUM_CMD      = 1 << CMD_NUM_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CMD_NUM_WIDTH-1:0]   cmd_num_i,
  input  logic [CMD_W*NUM_CMD-1:0]   cmd_dat_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  output logic                       done_o,
  output logic                       abort_o,
  output logic                       timeout_o,
  output logic                       busy_o,
  output logic [CMD_NUM_WIDTH-1:0]   cmd_idx_o,
  output logic [MV_X_WIDTH-1:0]      center_x_o,
  output logic [MV_Y_WIDTH-1:0]      center_y_o,
  output logic [MV_X_WIDTH-2:0]      length_x_o,
  output logic [MV_Y_WIDTH-2:0]      length_y_o,
  output logic [1:0]                 slope_o,
  output logic                       downsample_o,
  output logic                       use_feedback_o,
  output logic                       start_adr_o,
  output logic                       start_dec_o,
  output logic                       start_dmp_o,
  input  logic                       done_adr_i,
  input  logic                       done_dec_i,
  input  logic                       done_dmp_i
);

  typedef enum logic [2:0] {StIdle, StUpdate, StBusyAdr, StBusyDec, StBusyDmp} state_e;

  state_e                     r_state;
  logic [CMD_NUM_WIDTH-1:0]   r_cmd_idx;
  logic [CMD_NUM_WIDTH-1:0]   r_cmd_num;
  logic                       r_partition;
  logic                       r_done, r_abort, r_timeout;
  logic                       r_start_adr, r_start_dec, r_start_dmp;
  logic [MV_X_WIDTH-1:0]      r_center_x;
  logic [MV_Y_WIDTH-1:0]      r_center_y;
  logic [MV_X_WIDTH-2:0]      r_length_x;
  logic [MV_Y_WIDTH-2:0]      r_length_y;
  logic [1:0]                 r_slope;
  logic                       r_downsample, r_use_feedback;

  logic [CMD_W-1:0]           w_cmd;
  logic                       w_en, w_ds, w_part, w_fb;
  logic [MV_X_WIDTH-1:0]      w_cx;
  logic [MV_Y_WIDTH-1:0]      w_cy;
  logic [MV_X_WIDTH-2:0]      w_lx;
  logic [MV_Y_WIDTH-2:0]      w_ly;
  logic [1:0]                 w_slope;
  logic                       w_last, w_busy_ph, w_dec_done, w_stop, w_wdt_fire;

  assign w_cmd = cmd_dat_i[CMD_W*r_cmd_idx +: CMD_W];
  assign {w_en, w_cx, w_cy, w_lx, w_ly, w_slope, w_ds, w_part, w_fb} = w_cmd;

  assign w_last     = (r_cmd_idx == r_cmd_num);
  assign w_busy_ph  = (r_state == StBusyAdr) || (r_state == StBusyDec) || (r_state == StBusyDmp);
  // Decision is skipped for non-partitioned commands, except the last one which always decides.
  assign w_dec_done = done_dec_i || (!r_partition && !w_last);
  assign w_stop     = (r_state != StIdle) && (abort_i || w_wdt_fire);

`ifdef IME_CTRL_SEQ_WDT_EN
  localparam logic [WDT_WIDTH-1:0] WdtLast = {{(WDT_WIDTH-1){1'b1}}, 1'b0};

  logic [WDT_WIDTH-1:0] r_wdt;
  logic                 w_leave;

  assign w_leave = ((r_state == StBusyAdr) && done_adr_i) ||
                   ((r_state == StBusyDec) && w_dec_done) ||
                   ((r_state == StBusyDmp) && done_dmp_i);
  // Fires on the cycle the count would reach all-ones, so the stop lands right then.
  assign w_wdt_fire = w_busy_ph && (r_wdt == WdtLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt <= '0;
    end else if (!w_busy_ph || w_leave || w_stop) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + 1'b1;
    end
  end
`else
  assign w_wdt_fire = 1'b0 & (WDT_WIDTH != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_cmd_idx      <= '0;
      r_cmd_num      <= '0;
      r_partition    <= 1'b0;
      r_done         <= 1'b0;
      r_abort        <= 1'b0;
      r_timeout      <= 1'b0;
      r_start_adr    <= 1'b0;
      r_start_dec    <= 1'b0;
      r_start_dmp    <= 1'b0;
      r_center_x     <= '0;
      r_center_y     <= '0;
      r_length_x     <= '0;
      r_length_y     <= '0;
      r_slope        <= '0;
      r_downsample   <= 1'b0;
      r_use_feedback <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_timeout   <= 1'b0;
      r_start_adr <= 1'b0;
      r_start_dec <= 1'b0;
      r_start_dmp <= 1'b0;
      if (w_stop) begin
        r_state   <= StIdle;
        r_done    <= 1'b1;
        r_abort   <= 1'b1;
        r_timeout <= w_wdt_fire;
        r_cmd_idx <= '0;
      end else begin
        case (r_state)
          StIdle: begin
            if (start_i) begin
              r_state   <= StUpdate;
              r_cmd_num <= cmd_num_i;
              r_cmd_idx <= '0;
            end
          end
          StUpdate: begin
            r_center_x     <= w_cx;
            r_center_y     <= w_cy;
            r_length_x     <= w_lx;
            r_length_y     <= w_ly;
            r_slope        <= w_slope;
            r_downsample   <= w_ds;
            r_use_feedback <= w_fb;
            r_partition    <= w_part;
            if (!w_en && !w_last) begin
              r_cmd_idx <= r_cmd_idx + 1'b1;
            end else begin
              r_state     <= StBusyAdr;
              r_start_adr <= 1'b1;
            end
          end
          StBusyAdr: begin
            if (done_adr_i) begin
              r_state     <= StBusyDec;
              r_start_dec <= r_partition || w_last;
            end
          end
          StBusyDec: begin
            if (w_dec_done) begin
              if (w_last) begin
                r_state     <= StBusyDmp;
                r_start_dmp <= 1'b1;
              end else begin
                r_state   <= StUpdate;
                r_cmd_idx <= r_cmd_idx + 1'b1;
              end
            end
          end
          StBusyDmp: begin
            if (done_dmp_i) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign done_o         = r_done;
  assign abort_o        = r_abort;
  assign timeout_o      = r_timeout;
  assign busy_o         = (r_state != StIdle);
  assign cmd_idx_o      = r_cmd_idx;
  assign center_x_o     = r_center_x;
  assign center_y_o     = r_center_y;
  assign length_x_o     = r_length_x;
  assign length_y_o     = r_length_y;
  assign slope_o        = r_slope;
  assign downsample_o   = r_downsample;
  assign use_feedback_o = r_use_feedback;
  assign start_adr_o    = r_start_adr;
  assign start_dec_o    = r_start_dec;
  assign start_dmp_o    = r_start_dmp;

endmodule

// File: tb/tb_ime_ctrl_seq.sv
// Directed self-checking bench for ime_ctrl_seq (default parameters, WDT_WIDTH=4).
module tb_ime_ctrl_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   cmd_num_i = '0;
  logic [239:0] cmd_dat_i = '0;
  logic         start_i = 1'b0, abort_i = 1'b0;
  logic         done_adr_i = 1'b0, done_dec_i = 1'b0, done_dmp_i = 1'b0;
  logic         done_o, abort_o, timeout_o, busy_o;
  logic [2:0]   cmd_idx_o;
  logic [6:0]   center_x_o;
  logic [5:0]   center_y_o;
  logic [5:0]   length_x_o;
  logic [4:0]   length_y_o;
  logic [1:0]   slope_o;
  logic         downsample_o, use_feedback_o;
  logic         start_adr_o, start_dec_o, start_dmp_o;

  int n_cmp = 0, n_err = 0;
  int n_adr = 0, n_dec = 0, n_dmp = 0, n_done = 0;

  ime_ctrl_seq #(.WDT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_num_i(cmd_num_i), .cmd_dat_i(cmd_dat_i),
    .start_i(start_i), .abort_i(abort_i), .done_o(done_o), .abort_o(abort_o),
    .timeout_o(timeout_o), .busy_o(busy_o), .cmd_idx_o(cmd_idx_o),
    .center_x_o(center_x_o), .center_y_o(center_y_o), .length_x_o(length_x_o),
    .length_y_o(length_y_o), .slope_o(slope_o), .downsample_o(downsample_o),
    .use_feedback_o(use_feedback_o), .start_adr_o(start_adr_o),
    .start_dec_o(start_dec_o), .start_dmp_o(start_dmp_o), .done_adr_i(done_adr_i),
    .done_dec_i(done_dec_i), .done_dmp_i(done_dmp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] mk(input logic en, input logic [6:0] cx, input logic [5:0] cy,
                                     input logic [5:0] lx, input logic [4:0] ly,
                                     input logic [1:0] sl, input logic ds, input logic pt,
                                     input logic fb);
    return {en, cx, cy, lx, ly, sl, ds, pt, fb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (start_adr_o) n_adr++;
    if (start_dec_o) n_dec++;
    if (start_dmp_o) n_dmp++;
    if (done_o) n_done++;
  endtask

  task automatic clr_cnt();
    n_adr = 0; n_dec = 0; n_dmp = 0; n_done = 0;
  endtask

  // Start pulse, then step into the first BUSY_ADR cycle.
  task automatic kick();
    start_i = 1'b1; step(); start_i = 1'b0; step();
  endtask

  task automatic pulse_adr(); done_adr_i = 1'b1; step(); done_adr_i = 1'b0; endtask
  task automatic pulse_dec(); done_dec_i = 1'b1; step(); done_dec_i = 1'b0; endtask
  task automatic pulse_dmp(); done_dmp_i = 1'b1; step(); done_dmp_i = 1'b0; endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({done_o, abort_o, timeout_o, busy_o, start_adr_o, start_dec_o, start_dmp_o} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0000000", {done_o, abort_o, timeout_o, busy_o,
               start_adr_o, start_dec_o, start_dmp_o});
    end
    n_cmp++;
    if ({cmd_idx_o, center_x_o, center_y_o, length_x_o, length_y_o, slope_o, downsample_o,
         use_feedback_o} !== 33'b0) begin
      n_err++;
      $display("FAIL reset_cfg: got %h want 0", {cmd_idx_o, center_x_o, center_y_o, length_x_o,
               length_y_o, slope_o, downsample_o, use_feedback_o});
    end
    #2 rst = 1'b0;
    abort_i = 1'b1; step(); abort_i = 1'b0; step();
    n_cmp++;
    if ({busy_o, done_o, abort_o} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_abort: got %b want 000", {busy_o, done_o, abort_o});
    end
  endtask

  task automatic test_single();
    cmd_num_i = 3'd0;
    cmd_dat_i = '0;
    cmd_dat_i[0 +: 30] = mk(1'b1, 7'd5, 6'h3D, 6'd10, 5'd4, 2'd2, 1'b1, 1'b0, 1'b1);
    clr_cnt();
    start_i = 1'b1; step(); start_i = 1'b0;
    n_cmp++;
    if ({busy_o, start_adr_o} !== 2'b10) begin
      n_err++; $display("FAIL single_update: got %b want 10", {busy_o, start_adr_o});
    end
    step();
    n_cmp++;
    if (start_adr_o !== 1'b1) begin
      n_err++; $display("FAIL single_adr_lat: got %b want 1", start_adr_o);
    end
    n_cmp++;
    if ({center_x_o, center_y_o, length_x_o, length_y_o, slope_o, downsample_o, use_feedback_o}
        !== {7'd5, 6'h3D, 6'd10, 5'd4, 2'd2, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL single_cfg: got cx=%0d cy=%h lx=%0d ly=%0d sl=%0d ds=%b fb=%b", center_x_o,
               center_y_o, length_x_o, length_y_o, slope_o, downsample_o, use_feedback_o);
    end
    pulse_adr();
    n_cmp++;
    if (start_dec_o !== 1'b1) begin
      n_err++; $display("FAIL single_dec_forced: got %b want 1", start_dec_o);
    end
    pulse_dec();
    n_cmp++;
    if (start_dmp_o !== 1'b1) begin
      n_err++; $display("FAIL single_dmp: got %b want 1", start_dmp_o);
    end
    pulse_dmp();
    n_cmp++;
    if ({done_o, abort_o, timeout_o, busy_o} !== 4'b1000) begin
      n_err++;
      $display("FAIL single_done: got %b want 1000", {done_o, abort_o, timeout_o, busy_o});
    end
    step();
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++; $display("FAIL single_done_width: got %b want 0", done_o);
    end
  endtask

  task automatic test_two_cmds();
    cmd_num_i = 3'd1;
    cmd_dat_i = '0;
    cmd_dat_i[0 +: 30]  = mk(1'b1, 7'd1, 6'd1, 6'd1, 5'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    cmd_dat_i[30 +: 30] = mk(1'b1, 7'd2, 6'd2, 6'd2, 5'd2, 2'd1, 1'b0, 1'b1, 1'b0);
    clr_cnt();
    kick();
    pulse_adr();
    n_cmp++;
    if ({start_dec_o, busy_o} !== 2'b01) begin
      n_err++; $display("FAIL two_no_dec: got %b want 01", {start_dec_o, busy_o});
    end
    step();
    n_cmp++;
    if (cmd_idx_o !== 3'd1) begin
      n_err++; $display("FAIL two_idx: got %0d want 1", cmd_idx_o);
    end
    step();
    n_cmp++;
    if ({start_adr_o, center_x_o} !== {1'b1, 7'd2}) begin
      n_err++; $display("FAIL two_adr2: got adr=%b cx=%0d want adr=1 cx=2", start_adr_o, center_x_o);
    end
    pulse_adr(); pulse_dec(); pulse_dmp();
    n_cmp++;
    if ({n_adr, n_dec, n_dmp, n_done} !== {32'd2, 32'd1, 32'd1, 32'd1}) begin
      n_err++;
      $display("FAIL two_counts: got adr=%0d dec=%0d dmp=%0d done=%0d want 2 1 1 1", n_adr, n_dec,
               n_dmp, n_done);
    end
  endtask

  task automatic test_skip();
    int cyc;
    cmd_num_i = 3'd3;
    cmd_dat_i = '0;
    cmd_dat_i[0 +: 30]  = mk(1'b1, 7'd10, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    cmd_dat_i[30 +: 30] = mk(1'b0, 7'd11, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    cmd_dat_i[60 +: 30] = mk(1'b0, 7'd12, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    cmd_dat_i[90 +: 30] = mk(1'b0, 7'd13, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    clr_cnt();
    kick();
    n_cmp++;
    if ({start_adr_o, cmd_idx_o} !== {1'b1, 3'd0}) begin
      n_err++; $display("FAIL skip_first: got adr=%b idx=%0d want 1 0", start_adr_o, cmd_idx_o);
    end
    pulse_adr(); pulse_dec();
    cyc = 0;
    while (!start_adr_o && cyc < 20) begin step(); cyc++; end
    n_cmp++;
    if ({start_adr_o, cmd_idx_o, center_x_o} !== {1'b1, 3'd3, 7'd13} || cyc != 3) begin
      n_err++;
      $display("FAIL skip_last: got adr=%b idx=%0d cx=%0d cyc=%0d want 1 3 13 3", start_adr_o,
               cmd_idx_o, center_x_o, cyc);
    end
    pulse_adr();
    n_cmp++;
    if (start_dec_o !== 1'b1) begin
      n_err++; $display("FAIL skip_last_dec: got %b want 1", start_dec_o);
    end
    pulse_dec(); pulse_dmp();
    n_cmp++;
    if ({n_adr, n_done} !== {32'd2, 32'd1}) begin
      n_err++; $display("FAIL skip_counts: got adr=%0d done=%0d want 2 1", n_adr, n_done);
    end
  endtask

  task automatic test_ignore();
    cmd_num_i = 3'd0;
    cmd_dat_i = '0;
    cmd_dat_i[0 +: 30] = mk(1'b1, 7'd7, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    clr_cnt();
    kick();
    start_i = 1'b1; cmd_num_i = 3'd3; done_dec_i = 1'b1; done_dmp_i = 1'b1;
    step();
    start_i = 1'b0; done_dec_i = 1'b0; done_dmp_i = 1'b0;
    n_cmp++;
    if ({busy_o, start_dec_o, start_dmp_o, done_o, cmd_idx_o} !== {4'b1000, 3'd0}) begin
      n_err++;
      $display("FAIL ignore_stray: got %b want 1000000", {busy_o, start_dec_o, start_dmp_o, done_o,
               cmd_idx_o});
    end
    pulse_adr();
    n_cmp++;
    if (start_dec_o !== 1'b1) begin
      n_err++; $display("FAIL ignore_num_latched: got %b want 1", start_dec_o);
    end
    pulse_dec(); pulse_dmp();
    n_cmp++;
    if ({n_adr, n_done, done_o} !== {32'd1, 32'd1, 1'b1}) begin
      n_err++; $display("FAIL ignore_done: got adr=%0d done=%0d want 1 1", n_adr, n_done);
    end
  endtask

  task automatic test_abort();
    cmd_num_i = 3'd0;
    cmd_dat_i = '0;
    cmd_dat_i[0 +: 30] = mk(1'b1, 7'd3, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    kick();
    pulse_adr();
    clr_cnt();
    abort_i = 1'b1; done_dec_i = 1'b1; step(); abort_i = 1'b0; done_dec_i = 1'b0;
    n_cmp++;
    if ({done_o, abort_o, timeout_o, busy_o, start_dmp_o, cmd_idx_o} !== {5'b11000, 3'd0}) begin
      n_err++;
      $display("FAIL abort_stop: got %b want 11000000", {done_o, abort_o, timeout_o, busy_o,
               start_dmp_o, cmd_idx_o});
    end
    step();
    n_cmp++;
    if ({done_o, abort_o, n_dmp} !== {2'b00, 32'd0}) begin
      n_err++; $display("FAIL abort_after: got done=%b abort=%b dmp=%0d", done_o, abort_o, n_dmp);
    end
    start_i = 1'b1; abort_i = 1'b1; step(); start_i = 1'b0; abort_i = 1'b0;
    n_cmp++;
    if ({busy_o, done_o} !== 2'b10) begin
      n_err++; $display("FAIL abort_restart: got %b want 10", {busy_o, done_o});
    end
    step();
    n_cmp++;
    if (start_adr_o !== 1'b1) begin
      n_err++; $display("FAIL abort_restart_adr: got %b want 1", start_adr_o);
    end
    pulse_adr(); pulse_dec(); pulse_dmp();
    n_cmp++;
    if ({done_o, abort_o} !== 2'b10) begin
      n_err++; $display("FAIL abort_rerun_done: got %b want 10", {done_o, abort_o});
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    cmd_num_i = 3'd0;
    cmd_dat_i = '0;
    cmd_dat_i[0 +: 30] = mk(1'b1, 7'd1, 6'd0, 6'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    kick();
    cyc = 0;
`ifdef IME_CTRL_SEQ_WDT_EN
    while (!done_o && cyc < 40) begin step(); cyc++; end
    n_cmp++;
    if ({done_o, abort_o, timeout_o, busy_o} !== 4'b1110 || cyc != 15) begin
      n_err++;
      $display("FAIL wdt_fire: got %b cyc=%0d want 1110 cyc=15", {done_o, abort_o, timeout_o,
               busy_o}, cyc);
    end
`else
    while (!done_o && cyc < 40) begin step(); cyc++; end
    n_cmp++;
    if ({done_o, timeout_o, busy_o} !== 3'b001) begin
      n_err++; $display("FAIL wdt_off_busy: got %b want 001", {done_o, timeout_o, busy_o});
    end
    abort_i = 1'b1; step(); abort_i = 1'b0;
    n_cmp++;
    if ({done_o, abort_o, timeout_o, busy_o} !== 4'b1100) begin
      n_err++;
      $display("FAIL wdt_off_abort: got %b want 1100", {done_o, abort_o, timeout_o, busy_o});
    end
`endif
  endtask

  task automatic test_reset_mid();
    cmd_num_i = 3'd0;
    cmd_dat_i = '0;
    cmd_dat_i[0 +: 30] = mk(1'b1, 7'd9, 6'd4, 6'd3, 5'd2, 2'd1, 1'b1, 1'b1, 1'b1);
    kick(); pulse_adr(); pulse_dec();
    n_cmp++;
    if ({busy_o, start_dmp_o} !== 2'b11) begin
      n_err++; $display("FAIL rstmid_in_dmp: got %b want 11", {busy_o, start_dmp_o});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, start_dmp_o, done_o, cmd_idx_o, center_x_o, center_y_o, slope_o} !== 25'b0) begin
      n_err++;
      $display("FAIL rstmid_async: got busy=%b dmp=%b idx=%0d cx=%0d", busy_o, start_dmp_o,
               cmd_idx_o, center_x_o);
    end
    #2 rst = 1'b0;
    clr_cnt();
    done_dmp_i = 1'b1; step(); done_dmp_i = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({n_done, 31'd0, busy_o} !== 64'd0) begin
      n_err++; $display("FAIL rstmid_no_done: got done=%0d busy=%b want 0 0", n_done, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_cmds();
    test_skip();
    test_ignore();
    test_abort();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
